// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: ownership, FSM states and counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Sized for the largest legal MEM_LATENCY (7) and STARVE_LIMIT (15).
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  function automatic logic grant_slot(input arb_state_e st);
    return (st == ARB_IDLE) || (st == ARB_RESP);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side buses of the arbiter; slave = arbiter view, master = requesters + memory.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic                   if_req_i;
  logic [XLEN-1:0]        if_addr_i;
  logic                   if_gnt_o;
  logic                   if_rvalid_o;
  logic [XLEN-1:0]        if_rdata_o;

  logic                   dm_req_i;
  logic                   dm_we_i;
  logic [XLEN-1:0]        dm_addr_i;
  logic [XLEN-1:0]        dm_wdata_i;
  logic [XLEN/8-1:0]      dm_be_i;
  logic                   dm_gnt_o;
  logic                   dm_rvalid_o;
  logic [XLEN-1:0]        dm_rdata_o;

  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [XLEN-1:0]        mem_addr_o;
  logic [XLEN-1:0]        mem_wdata_o;
  logic [XLEN/8-1:0]      mem_be_o;
  logic [XLEN-1:0]        mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; if_prio_i says whether fetch takes a tie
// (starvation guard tripped, or data won last in round-robin builds).
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  arb_state_e state_i,
  input  logic       en_i,
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  logic       if_prio_i,
  output owner_e     win_o
);

  always_comb begin
    win_o = OWN_NONE;
    if (en_i && grant_slot(state_i)) begin
      if (if_req_i && dm_req_i) begin
        win_o = if_prio_i ? OWN_IF : OWN_DM;
      end else if (dm_req_i) begin
        win_o = OWN_DM;
      end else if (if_req_i) begin
        win_o = OWN_IF;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port fixed-latency memory. Define MEM_ARB_ROUND_ROBIN_EN
// to replace fixed priority (data first, fetch starvation guard) with round-robin on ties.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY out of range 1..7");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  arb_state_e       state_q;
  owner_e           owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  owner_e           win;
  logic             if_prio;
  logic             resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dm_q;
  assign if_prio = last_dm_q;
`else
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  assign if_prio = (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (win == OWN_IF) begin
      starve_d = '0;
    end else if (win == OWN_DM && bus.if_req_i && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end
`endif

  mem_arb_pick u_pick (
    .state_i   (state_q),
    .en_i      (!rst_i),
    .if_req_i  (bus.if_req_i),
    .dm_req_i  (bus.dm_req_i),
    .if_prio_i (if_prio),
    .win_o     (win)
  );

  logic [XLEN-1:0]   addr_mux;
  logic [XLEN-1:0]   wdata_mux;
  logic [XLEN/8-1:0] be_mux;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    be_mux    = '0;
    case (win)
      OWN_IF: addr_mux = bus.if_addr_i;
      OWN_DM: begin
        addr_mux  = bus.dm_addr_i;
        wdata_mux = bus.dm_wdata_i;
        be_mux    = bus.dm_be_i;
      end
      default: ;
    endcase
  end

  assign bus.if_gnt_o    = (win == OWN_IF);
  assign bus.dm_gnt_o    = (win == OWN_DM);
  assign bus.mem_req_o   = (win != OWN_NONE);
  assign bus.mem_we_o    = (win == OWN_DM) && bus.dm_we_i;
  assign bus.mem_addr_o  = addr_mux;
  assign bus.mem_wdata_o = wdata_mux;
  assign bus.mem_be_o    = be_mux;

  // RESP coincides with the cycle the memory presents read data.
  assign resp            = (state_q == ARB_RESP) && !rst_i;
  assign bus.if_rvalid_o = resp && (owner_q == OWN_IF);
  assign bus.dm_rvalid_o = resp && (owner_q == OWN_DM);
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.dm_rdata_o  = (bus.dm_rvalid_o && !we_q) ? bus.mem_rdata_i : '0;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dm_q <= 1'b0;
`else
      starve_q <= '0;
`endif
    end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (win != OWN_NONE) begin
        last_dm_q <= (win == OWN_DM);
      end
`else
      starve_q <= starve_d;
`endif
      case (state_q)
        ARB_IDLE, ARB_RESP: begin
          if (win != OWN_NONE) begin
            owner_q <= win;
            we_q    <= (win == OWN_DM) && bus.dm_we_i;
            cnt_q   <= CNT_W'(1);
            state_q <= (LAT == CNT_W'(1)) ? ARB_RESP : ARB_ACCESS;
          end else begin
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_d;
          if (cnt_d == LAT) begin
            state_q <= ARB_RESP;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.if_gnt_o && bus.dm_gnt_o));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (MEM_LATENCY 1, 2, 3) against pipelined memory models.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   onehot_viol = 0;

  mem_port_arbiter_if #(.XLEN(32)) b1 ();
  mem_port_arbiter_if #(.XLEN(32)) b2 ();
  mem_port_arbiter_if #(.XLEN(32)) b3 ();

  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u1 (.clk_i(clk), .rst_i(rst1), .bus(b1));
  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u2 (.clk_i(clk), .rst_i(rst2), .bus(b2));
  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (.clk_i(clk), .rst_i(rst3), .bus(b3));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  // Memory data appears exactly MEM_LATENCY cycles after the request strobe.
  logic [31:0] m1_q;
  logic [31:0] m2_q [2];
  logic [31:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= b1.mem_req_o ? mem_word(b1.mem_addr_o) : 32'h0BAD0BAD;
    m2_q[0] <= b2.mem_req_o ? mem_word(b2.mem_addr_o) : 32'h0BAD0BAD;
    m2_q[1] <= m2_q[0];
    m3_q[0] <= b3.mem_req_o ? mem_word(b3.mem_addr_o) : 32'h0BAD0BAD;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign b1.mem_rdata_i = m1_q;
  assign b2.mem_rdata_i = m2_q[1];
  assign b3.mem_rdata_i = m3_q[2];

  always @(negedge clk) begin
    if ((b1.if_gnt_o && b1.dm_gnt_o) || (b2.if_gnt_o && b2.dm_gnt_o) || (b3.if_gnt_o && b3.dm_gnt_o))
      onehot_viol <= onehot_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  owner_e exp_w;
  owner_e prev_w;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    b1.if_req_i = 0; b1.if_addr_i = 0; b1.dm_req_i = 0; b1.dm_we_i = 0; b1.dm_addr_i = 0; b1.dm_wdata_i = 0; b1.dm_be_i = 0;
    b2.if_req_i = 0; b2.if_addr_i = 0; b2.dm_req_i = 0; b2.dm_we_i = 0; b2.dm_addr_i = 0; b2.dm_wdata_i = 0; b2.dm_be_i = 0;
    b3.if_req_i = 0; b3.if_addr_i = 0; b3.dm_req_i = 0; b3.dm_we_i = 0; b3.dm_addr_i = 0; b3.dm_wdata_i = 0; b3.dm_be_i = 0;
    repeat (2) cyc();

    // Reset holds every output low even with both requests raised
    b1.if_req_i = 1; b1.dm_req_i = 1; b1.if_addr_i = 32'h40; b1.dm_addr_i = 32'h80;
    mid();
    $display("[tx] reset with requests pending");
    chk("rst_if_gnt", b1.if_gnt_o, 0);
    chk("rst_dm_gnt", b1.dm_gnt_o, 0);
    chk("rst_mem_req", b1.mem_req_o, 0);
    chk("rst_if_rvalid", b1.if_rvalid_o, 0);
    chk("rst_dm_rvalid", b1.dm_rvalid_o, 0);
    chk("rst_state", 32'(u1.state_q), 32'(ARB_IDLE));
    cyc();
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

    // Both held high: tie-break sequence, each response routed one cycle later
    prev_w = OWN_NONE;
    for (int k = 0; k < 10; k++) begin
      mid();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = (k % 2 == 1) ? OWN_IF : OWN_DM;
`else
      exp_w = (k % 5 == 4) ? OWN_IF : OWN_DM;
`endif
      $display("[tx] tie grant %0d expect %s", k, (exp_w == OWN_IF) ? "if" : "dm");
      chk($sformatf("tie_if_gnt%0d", k), b1.if_gnt_o, exp_w == OWN_IF);
      chk($sformatf("tie_dm_gnt%0d", k), b1.dm_gnt_o, exp_w == OWN_DM);
      if (k > 0) begin
        chk($sformatf("tie_if_rv%0d", k), b1.if_rvalid_o, prev_w == OWN_IF);
        chk($sformatf("tie_dm_rv%0d", k), b1.dm_rvalid_o, prev_w == OWN_DM);
        if (prev_w == OWN_IF) chk($sformatf("tie_if_rd%0d", k), b1.if_rdata_o, 32'hC0DE0040);
        else                  chk($sformatf("tie_dm_rd%0d", k), b1.dm_rdata_o, 32'hC0DE0080);
      end
      prev_w = exp_w;
      cyc();
    end
    b1.if_req_i = 0; b1.dm_req_i = 0;
    mid();
    chk("tie_last_if_rv", b1.if_rvalid_o, 1);
    chk("tie_last_if_rd", b1.if_rdata_o, 32'hC0DE0040);
    chk("tie_last_mem_req", b1.mem_req_o, 0);
    cyc();

    // Lone fetch read, latency 1
    b1.if_req_i = 1; b1.if_addr_i = 32'h100;
    mid();
    $display("[tx] lone fetch read addr=100");
    chk("f1_if_gnt", b1.if_gnt_o, 1);
    chk("f1_dm_gnt", b1.dm_gnt_o, 0);
    chk("f1_mem_req", b1.mem_req_o, 1);
    chk("f1_mem_addr", b1.mem_addr_o, 32'h100);
    chk("f1_mem_we", b1.mem_we_o, 0);
    chk("f1_mem_be", 32'(b1.mem_be_o), 0);
    cyc();
    b1.if_req_i = 0;
    mid();
    chk("f1_if_rvalid", b1.if_rvalid_o, 1);
    chk("f1_if_rdata", b1.if_rdata_o, 32'hDEADBEEF);
    chk("f1_dm_rvalid", b1.dm_rvalid_o, 0);
    chk("f1_mem_req_off", b1.mem_req_o, 0);
    cyc();
    mid();
    chk("f1_if_rvalid_end", b1.if_rvalid_o, 0);
    cyc();

    // Data write: committed in grant cycle, ack with zero data
    b1.dm_req_i = 1; b1.dm_we_i = 1; b1.dm_addr_i = 32'h200; b1.dm_wdata_i = 32'h12345678; b1.dm_be_i = 4'b0011;
    mid();
    $display("[tx] data write addr=200 data=12345678 be=0011");
    chk("w_dm_gnt", b1.dm_gnt_o, 1);
    chk("w_mem_we", b1.mem_we_o, 1);
    chk("w_mem_be", 32'(b1.mem_be_o), 32'h3);
    chk("w_mem_addr", b1.mem_addr_o, 32'h200);
    chk("w_mem_wdata", b1.mem_wdata_o, 32'h12345678);
    cyc();
    b1.dm_req_i = 0; b1.dm_we_i = 0;
    mid();
    chk("w_dm_rvalid", b1.dm_rvalid_o, 1);
    chk("w_dm_rdata", b1.dm_rdata_o, 0);
    chk("w_if_rvalid", b1.if_rvalid_o, 0);
    cyc();

    // Latency 2: simultaneous reads, data first, fetch granted back-to-back in data's RESP
    b2.if_req_i = 1; b2.if_addr_i = 32'h300; b2.dm_req_i = 1; b2.dm_addr_i = 32'h304;
    mid();
    $display("[tx] L2 simultaneous reads if=300 dm=304");
    chk("l2_c0_dm_gnt", b2.dm_gnt_o, 1);
    chk("l2_c0_if_gnt", b2.if_gnt_o, 0);
    chk("l2_c0_addr", b2.mem_addr_o, 32'h304);
    cyc();
    b2.dm_req_i = 0;
    mid();
    chk("l2_c1_if_gnt", b2.if_gnt_o, 0);
    chk("l2_c1_mem_req", b2.mem_req_o, 0);
    chk("l2_c1_dm_rv", b2.dm_rvalid_o, 0);
    cyc();
    mid();
    chk("l2_c2_dm_rv", b2.dm_rvalid_o, 1);
    chk("l2_c2_dm_rd", b2.dm_rdata_o, 32'hC0DE0304);
    chk("l2_c2_if_gnt", b2.if_gnt_o, 1);
    chk("l2_c2_addr", b2.mem_addr_o, 32'h300);
    cyc();
    b2.if_req_i = 0; b2.dm_req_i = 1; b2.dm_addr_i = 32'h308;
    mid();
    $display("[tx] L2 data request raised during ACCESS then dropped");
    chk("l2_c3_dm_gnt", b2.dm_gnt_o, 0);
    chk("l2_c3_if_rv", b2.if_rvalid_o, 0);
    cyc();
    b2.dm_req_i = 0;
    mid();
    chk("l2_c4_if_rv", b2.if_rvalid_o, 1);
    chk("l2_c4_if_rd", b2.if_rdata_o, 32'hC0DE0300);
    chk("l2_c4_dm_rv", b2.dm_rvalid_o, 0);
    chk("l2_c4_mem_req", b2.mem_req_o, 0);
    cyc();
    mid();
    chk("l2_c5_if_rv", b2.if_rvalid_o, 0);
    chk("l2_c5_state", 32'(u2.state_q), 32'(ARB_IDLE));
    cyc();

    // Latency 3: reset during fetch ACCESS discards the response
    b3.if_req_i = 1; b3.if_addr_i = 32'h500;
    mid();
    $display("[tx] L3 fetch addr=500 then reset mid-flight");
    chk("l3_c0_if_gnt", b3.if_gnt_o, 1);
    cyc();
    b3.if_req_i = 0; rst3 = 1'b1;
    mid();
    chk("l3_c1_if_rv", b3.if_rvalid_o, 0);
    chk("l3_c1_if_gnt", b3.if_gnt_o, 0);
    cyc();
    rst3 = 1'b0; b3.dm_req_i = 1; b3.dm_addr_i = 32'h600;
    mid();
    chk("l3_c2_state", 32'(u3.state_q), 32'(ARB_IDLE));
    chk("l3_c2_dm_gnt", b3.dm_gnt_o, 1);
    chk("l3_c2_if_rv", b3.if_rvalid_o, 0);
    cyc();
    b3.dm_req_i = 0;
    for (int k = 3; k < 5; k++) begin
      mid();
      chk($sformatf("l3_c%0d_if_rv", k), b3.if_rvalid_o, 0);
      chk($sformatf("l3_c%0d_dm_rv", k), b3.dm_rvalid_o, 0);
      cyc();
    end
    mid();
    chk("l3_c5_dm_rv", b3.dm_rvalid_o, 1);
    chk("l3_c5_dm_rd", b3.dm_rdata_o, 32'hC0DE0600);
    chk("l3_c5_if_rv", b3.if_rvalid_o, 0);
    cyc();

    chk("gnt_onehot", onehot_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
